// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, accesses a little-endian word array and returns a
// one-cycle response carrying extended load data or an alignment error.
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CW    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, signed_q, err_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rd_word_q;
  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                req_misaligned;
  logic [ADDR_W-1:0]   word_idx;
  logic [3:0]          lane_en;
  logic [31:0]         lane_data;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [31:0]         load_ext;
  logic                unused_addr;

  // Address bits above the array window are ignored, so addresses wrap.
  assign unused_addr    = ^req_addr[31:ADDR_W+2];
  assign accept         = req_valid && (state_q == S_IDLE);
  assign req_misaligned = (req_size == 2'b11) ||
                          (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign word_idx       = addr_q[ADDR_W+1:2];

  // Next-state logic: IDLE -> (WAIT ->) ACCESS -> RESP -> IDLE, errors skip to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_misaligned) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, wait counter and captured request; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr[ADDR_W+1:0];
        wdata_q  <= req_wdata;
        err_q    <= req_misaligned;
      end
    end
  end

  // Per-lane write enables and store data steered into little-endian lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (size_q == 2'b10) ||
                         (size_q == 2'b01 && addr_q[1] == LANE[1]) ||
                         (size_q == 2'b00 && addr_q[1:0] == LANE);
    assign lane_data[8*gi +: 8] = (size_q == 2'b00) ? wdata_q[7:0] :
                                  (size_q == 2'b01) ? wdata_q[8*(gi%2) +: 8] :
                                                      wdata_q[8*gi +: 8];
  end

  // Word array: byte-lane write in ACCESS (suppressed by reset), registered read.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_ACCESS && we_q) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
      end
    end
    rd_word_q <= mem[word_idx];
  end

  // Lane selection and sign/zero extension of the word read during ACCESS.
  always_comb begin
    byte_lane = rd_word_q[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    load_ext  = '0;
    case (size_q)
      2'b00:   load_ext = signed_q ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
      2'b01:   load_ext = signed_q ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
      2'b10:   load_ext = rd_word_q;
      default: load_ext = '0;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed cases plus randomized
// traffic compared against a byte-addressed memory model.
module tb_dm_responder;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  int n_run  = 0;
  int n_fail = 0;

  // Model memory: one byte per address over the 4 KiB window (ADDR_W=10).
  logic [7:0] mem_b [4096];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    int a;
    logic [31:0] v;
    a = int'(addr % 4096);
    if (size == 2'd0) begin
      v = {24'h0, mem_b[a]};
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else if (size == 2'd1) begin
      v = {16'h0, mem_b[a+1], mem_b[a]};
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
    end
    return v;
  endfunction

  task automatic m_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    int nb;
    a  = int'(addr % 4096);
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    for (int i = 0; i < nb; i++) mem_b[a+i] = wd[8*i +: 8];
  endtask

  // Drives one request, returns edges from accept (accept edge = 1) to rsp_valid.
  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output int edges, output logic [31:0] rd, output logic er,
                      output logic rdy);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 1;
    while (rsp_valid !== 1'b1 && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
    $display("[TB] xact we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d edges=%0d",
             we, size, sgn, addr, wd, rd, er, edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({rsp_valid, rsp_err, busy, req_ready} !== 4'b0001 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b err=%b busy=%b ready=%b rdata=%h required 0 0 0 1 0",
               rsp_valid, rsp_err, busy, req_ready, rsp_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic preload();
    int e; logic [31:0] rd; logic er, rdy;
    for (int i = 0; i < 64; i++) begin
      xact(1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h0, e, rd, er, rdy);
      m_store(2'd2, 32'(i * 4), 32'h0);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  task automatic test_directed();
    vec_t v [10];
    int e; logic [31:0] rd; logic er, rdy;
    v[0] = mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0);
    v[1] = mk(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADBEEF);
    v[2] = mk(1, 2'd0, 0, 32'h11, 32'h000000AA, 32'h0);
    v[3] = mk(0, 2'd0, 1, 32'h11, 32'h0,        32'hFFFFFFAA);
    v[4] = mk(0, 2'd0, 0, 32'h11, 32'h0,        32'h000000AA);
    v[5] = mk(0, 2'd2, 0, 32'h10, 32'h0,        32'hDEADAAEF);
    v[6] = mk(1, 2'd1, 0, 32'h12, 32'h00008001, 32'h0);
    v[7] = mk(0, 2'd1, 1, 32'h12, 32'h0,        32'hFFFF8001);
    v[8] = mk(0, 2'd1, 0, 32'h12, 32'h0,        32'h00008001);
    v[9] = mk(0, 2'd2, 0, 32'h10, 32'h0,        32'h8001AAEF);
    for (int i = 0; i < 10; i++) begin
      xact(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wd, e, rd, er, rdy);
      if (v[i].we) m_store(v[i].size, v[i].addr, v[i].wd);
      n_run++;
      if (rd !== v[i].exp || er !== 1'b0 || e != W + 2 || rdy !== 1'b1) begin
        n_fail++;
        $display("FAIL directed[%0d]: got rdata=%h err=%b edges=%0d ready=%b required rdata=%h err=0 edges=%0d ready=1",
                 i, rd, er, e, rdy, v[i].exp, W + 2);
      end
    end
  endtask

  task automatic test_errors();
    vec_t v [6];
    int e; logic [31:0] rd; logic er, rdy;
    v[0] = mk(0, 2'd2, 0, 32'h13, 32'h0, 32'h0);
    v[1] = mk(0, 2'd1, 1, 32'h11, 32'h0, 32'h0);
    v[2] = mk(0, 2'd3, 0, 32'h10, 32'h0, 32'h0);
    v[3] = mk(1, 2'd2, 0, 32'h13, 32'hFFFFFFFF, 32'h0);
    v[4] = mk(1, 2'd1, 0, 32'h11, 32'h0000FFFF, 32'h0);
    v[5] = mk(1, 2'd3, 0, 32'h10, 32'h12345678, 32'h0);
    for (int i = 0; i < 6; i++) begin
      xact(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wd, e, rd, er, rdy);
      n_run++;
      if (rd !== 32'h0 || er !== 1'b1 || e != 1) begin
        n_fail++;
        $display("FAIL error[%0d]: got rdata=%h err=%b edges=%0d required rdata=0 err=1 edges=1",
                 i, rd, er, e);
      end
    end
    xact(0, 2'd2, 0, 32'h10, 32'h0, e, rd, er, rdy);
    n_run++;
    if (rd !== 32'h8001AAEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL error_untouched: got %h err=%b required 8001aaef err=0", rd, er);
    end
  endtask

  task automatic test_random();
    int e; logic [31:0] rd, exp, addr, wd; logic er, rdy, we, sgn, xerr;
    logic [1:0] size;
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      addr[11:8] = 4'h0;
      wd   = $urandom;
      xerr = m_err(size, addr);
      exp  = (xerr || we) ? 32'h0 : m_load(size, sgn, addr);
      xact(we, size, sgn, addr, wd, e, rd, er, rdy);
      if (!xerr && we) m_store(size, addr, wd);
      n_run++;
      if (rd !== exp || er !== xerr || e != (xerr ? 1 : W + 2)) begin
        n_fail++;
        $display("FAIL random[%0d]: got rdata=%h err=%b edges=%0d required rdata=%h err=%b edges=%0d",
                 i, rd, er, e, exp, xerr, xerr ? 1 : W + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q_exp [$];
    logic [31:0] addr, wd, exp;
    logic [1:0]  size;
    logic        we, sgn, rdy, bsy;
    int          last_acc = -1;
    int          drain;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      we   = 1'($urandom);
      sgn  = 1'($urandom);
      size = 2'($urandom_range(0, 2));
      addr = $urandom;
      addr[11:8] = 4'h0;
      if (size == 2'd1) addr[0] = 1'b0;
      if (size == 2'd2) addr[1:0] = 2'b00;
      wd = $urandom;
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      rdy = req_ready;
      bsy = busy;
      n_run++;
      if (rdy !== !bsy) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: got ready=%b busy=%b required ready = !busy", cyc, rdy, bsy);
      end
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) begin
        n_run++;
        if (q_exp.size() == 0 || rsp_rdata !== q_exp[0] || rsp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b required rdata=%h err=0",
                   cyc, rsp_rdata, rsp_err, (q_exp.size() != 0) ? q_exp[0] : 32'h0);
        end
        if (q_exp.size() != 0) void'(q_exp.pop_front());
      end
      if (rdy) begin
        exp = we ? 32'h0 : m_load(size, sgn, addr);
        if (we) m_store(size, addr, wd);
        q_exp.push_back(exp);
        $display("[TB] b2b accept cyc=%0d we=%0d size=%0d addr=%h exp=%h", cyc, we, size, addr, exp);
        if (last_acc >= 0) begin
          n_run++;
          if (cyc - last_acc != W + 3) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles required %0d", cyc, cyc - last_acc, W + 3);
          end
        end
        last_acc = cyc;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain = 0;
    while (q_exp.size() != 0 && drain < 10) begin
      @(posedge clk); #1;
      drain++;
      if (rsp_valid === 1'b1) begin
        n_run++;
        if (rsp_rdata !== q_exp[0] || rsp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_drain: got rdata=%h err=%b required rdata=%h err=0", rsp_rdata, rsp_err, q_exp[0]);
        end
        void'(q_exp.pop_front());
      end
    end
    n_run++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_missing: got %0d responses outstanding required 0", q_exp.size());
    end
    repeat (2) @(posedge clk);
  endtask

  // Abort a store with reset k edges after the accept edge (k=0: WAIT, k=2: ACCESS).
  task automatic test_reset_abort(input logic [31:0] addr, input int k);
    int e; logic [31:0] rd, exp; logic er, rdy;
    int seen;
    exp = m_load(2'd2, 1'b0, addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = addr; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (k) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state[k=%0d]: got busy=%b ready=%b valid=%b required 0 1 0",
               k, busy, req_ready, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    n_run++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_rsp[k=%0d]: got %0d responses required 0", k, seen);
    end
    xact(0, 2'd2, 0, addr, 32'h0, e, rd, er, rdy);
    n_run++;
    if (rd !== exp || er !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_data[k=%0d]: got %h err=%b required %h err=0", k, rd, er, exp);
    end
  endtask

  task automatic test_retained();
    int e; logic [31:0] rd, exp; logic er, rdy;
    exp = m_load(2'd2, 1'b0, 32'h10);
    xact(0, 2'd2, 0, 32'h10, 32'h0, e, rd, er, rdy);
    n_run++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL retained_after_reset: got %h required %h", rd, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
    test_reset();
    preload();
    test_directed();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_abort(32'h20, 0);
    test_reset_abort(32'h24, 2);
    test_retained();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
